multicycle_adder_nbits: RTL and testbench
=========================================

# multicycle_adder_nbits

Sequential n-bit adder that computes S = A + B + Cin over several clock cycles, processing one `chunk`-bit slice per cycle and holding the inter-slice carry in a register. It is the additive counterpart of the ALU's ripple-borrow subtractor. It serves datapaths where a full-width single-cycle carry chain would limit the clock frequency. Operation is started by a one-cycle `start` pulse and completion is flagged by a one-cycle `done` pulse.

## Interface
- `bits`, default 32: operand and result width; must be a positive multiple of `chunk`.
- `chunk`, default 8: slice width added per cycle; N = bits/chunk slices.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a new addition; sampled only when not busy.
- `Cin`, input, 1: carry-in; latched with the operands.
- `A`, input, `bits`: first operand; latched on an accepted start.
- `B`, input, `bits`: second operand; latched on an accepted start.
- `busy`, output, 1: high while slices are being computed.
- `done`, output, 1: one-cycle pulse when `S`, `Cout` and `V` become valid.
- `S`, output, `bits`: sum.
- `Cout`, output, 1: carry out of bit `bits-1`.
- `V`, output, 1: signed overflow flag; see Configuration.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `busy` = 0 and `done` = 0.
  - When `start` = 1, latch `A`, `B` and `Cin` into internal registers.
  - Set slice index k = 0 and the carry register to `Cin`, then go to RUN.
- RUN:
  - Each cycle, add slice k of both latched operands plus the carry register.
  - Write the `chunk`-bit result to `S[k*chunk +: chunk]` and the slice carry-out to the carry register.
  - Increment k.
  - After slice N-1: set `Cout` to that slice's carry-out, compute `V`, and go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle.
  - Go to IDLE, or accept a new `start` directly with the same behaviour as in IDLE.
- `start` in RUN is ignored; no queuing.
- Changes on `A`, `B` or `Cin` after acceptance do not affect the result.
- `S`, `Cout` and `V` hold their values from the DONE cycle until the next accepted start.
  - From the first RUN edge onward, `S` shows partial slices and `Cout`/`V` are undefined until the next `done`.
- Arithmetic is modulo 2^bits; `Cout` = bit `bits` of the exact sum A+B+Cin.
- Overflow: V = (A[bits-1] == B[bits-1]) && (S[bits-1] != A[bits-1]), using the latched operands.
- Reset: all outputs are 0 (`S`, `Cout`, `V`, `busy`, `done`), the state is IDLE, and k and the carry register are 0.
- Reset mid-RUN aborts the operation: no `done` is produced and the partial `S` is cleared.

## Timing
- An accepted start at edge t enters RUN.
- Slices are computed on edges t+1 through t+N.
- DONE is entered at edge t+N: `done` is high and results are valid from t+N until t+N+1.
- Latency from start to `done` is N cycles; with the defaults this is 4.
- `busy` is high from edge t until edge t+N.
- Back-to-back: `start` held during the DONE cycle is accepted at edge t+N+1, giving a throughput of one result every N+1 cycles.
- Asynchronous reset takes effect immediately. Release is synchronous to the next edge.

## Configuration
- `MULTICYCLE_ADDER_OVERFLOW_EN`:
  - Defined: `V` is computed as above and registered with `Cout`.
  - Undefined: the overflow logic is not synthesized and `V` is tied to 0.
  - All other behaviour and timing are identical in both cases.

## Test plan
All cases use bits = 32 and chunk = 8.
- Carry ripple across all slices: A=0x0000_0001, B=0xFFFF_FFFF, Cin=0 → `done` 4 cycles after start; S=0x0000_0000, Cout=1, V=0.
- Signed overflow: A=0x7FFF_FFFF, B=0x0000_0001, Cin=0 → S=0x8000_0000, Cout=0. V=1 with the macro defined, V=0 without it.
- Carry-in: A=0x1234_5678, B=0x0000_00FF, Cin=1 → S=0x1234_5778, Cout=0, V=0.
- Start while busy: start with A=5, B=7; pulse start with A=1, B=1 two cycles later and change the operand inputs → `done` only once at cycle 4, S=0x0000_000C, `busy` stays high with no restart.
- Reset mid-RUN: assert `rst_n`=0 at cycle 2 of an operation → `S`, `Cout`, `V`, `busy` and `done` are 0 at once and no `done` follows. A later add of 3+4 gives S=7 with `done` after 4 cycles.
- Back-to-back: hold `start` high through the DONE cycle with new operands 0xFFFF_FFFF + 0xFFFF_FFFF → second `done` exactly 5 cycles after the first; S=0xFFFF_FFFE, Cout=1, V=0.

Source files
------------

// File: rtl/multicycle_adder_nbits.sv
// Sequential adder: one chunk-wide slice per cycle with a registered inter-slice carry.
// Optional signed-overflow flag enabled by defining MULTICYCLE_ADDER_OVERFLOW_EN.
module multicycle_adder_nbits #(
   parameter int bits  = 32,
   parameter int chunk = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            Cin,
   input  logic [bits-1:0] A,
   input  logic [bits-1:0] B,
   output logic            busy,
   output logic            done,
   output logic [bits-1:0] S,
   output logic            Cout,
   output logic            V
);

   localparam int N  = bits / chunk;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic              carry_q, carry_d;
   logic [bits-1:0]   a_q, a_d;
   logic [bits-1:0]   b_q, b_d;
   logic [bits-1:0]   s_q, s_d;
   logic              cout_q, cout_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [chunk-1:0]  a_slice, b_slice;
   logic [chunk:0]    slice_sum;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
   logic              v_q, v_d;
`endif

   always_comb begin
      a_slice   = a_q[k_q*chunk +: chunk];
      b_slice   = b_q[k_q*chunk +: chunk];
      slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{chunk{1'b0}}, carry_q};

      state_d = state_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cout_d  = cout_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
      v_d     = v_q;
`endif

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            if (start) begin
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            s_d[k_q*chunk +: chunk] = slice_sum[chunk-1:0];
            carry_d = slice_sum[chunk];
            if (k_q == KW'(N - 1)) begin
               // Last slice: its carry-out and MSB give Cout and overflow.
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               k_d     = '0;
               cout_d  = slice_sum[chunk];
`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
               v_d     = (a_q[bits-1] == b_q[bits-1]) &&
                         (slice_sum[chunk-1] != a_q[bits-1]);
`endif
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= 1'b0;
      else        v_q <= v_d;
   end
   assign V = v_q;
`else
   assign V = 1'b0;
`endif

   assign busy = busy_q;
   assign done = done_q;
   assign S    = s_q;
   assign Cout = cout_q;

endmodule

// File: tb/tb_multicycle_adder_nbits.sv
// Directed self-checking bench for multicycle_adder_nbits (bits=32, chunk=8).
module tb_multicycle_adder_nbits;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        Cin = 1'b0;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        busy, done, Cout, V;
   logic [31:0] S;

   int checks = 0;
   int errors = 0;

`ifdef MULTICYCLE_ADDER_OVERFLOW_EN
   localparam logic OVF_ON = 1'b1;
`else
   localparam logic OVF_ON = 1'b0;
`endif

   multicycle_adder_nbits #(.bits(32), .chunk(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .Cin(Cin), .A(A), .B(B),
      .busy(busy), .done(done), .S(S), .Cout(Cout), .V(V)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one operation and count edges until done (bounded at 20).
   task automatic run_add(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output int lat);
      A = a; B = b; Cin = cin; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic check_result(input string name, input int lat,
                               input logic [31:0] s_exp, input logic c_exp,
                               input logic v_exp);
      checks++;
      if (lat !== 4) begin
         errors++; $display("FAIL %s latency: got %0d expected 4", name, lat);
      end
      checks++;
      if (S !== s_exp) begin
         errors++; $display("FAIL %s S: got %h expected %h", name, S, s_exp);
      end
      checks++;
      if (Cout !== c_exp) begin
         errors++; $display("FAIL %s Cout: got %b expected %b", name, Cout, c_exp);
      end
      checks++;
      if (V !== v_exp) begin
         errors++; $display("FAIL %s V: got %b expected %b", name, V, v_exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({busy, done, Cout, V, S} !== 36'h0) begin
         errors++;
         $display("FAIL reset outputs: got busy=%b done=%b Cout=%b V=%b S=%h expected all 0",
                  busy, done, Cout, V, S);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL idle after reset: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   task automatic test_carry_ripple();
      int lat;
      run_add(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, lat);
      check_result("carry_ripple", lat, 32'h0000_0000, 1'b1, 1'b0);
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_pulse_width: got done=%b expected 0", done);
      end
   endtask

   task automatic test_overflow();
      int lat;
      run_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
      check_result("overflow", lat, 32'h8000_0000, 1'b0, OVF_ON);
      tick();
   endtask

   task automatic test_carry_in();
      int lat;
      run_add(32'h1234_5678, 32'h0000_00FF, 1'b1, lat);
      check_result("carry_in", lat, 32'h1234_5778, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_start_while_busy();
      int ndone;
      A = 32'd5; B = 32'd7; Cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 2) begin
            A = 32'd1; B = 32'd1; Cin = 1'b1; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) ndone++;
         if (c < 4) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL busy_ignore_start cycle %0d: got busy=%b done=%b expected 1 0",
                        c, busy, done);
            end
         end
         if (c == 4) begin
            checks++;
            if (done !== 1'b1 || S !== 32'h0000_000C) begin
               errors++;
               $display("FAIL busy_result: got done=%b S=%h expected 1 0000000c", done, S);
            end
         end
      end
      checks++;
      if (ndone !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_single_done: got done_count=%0d busy=%b expected 1 0", ndone, busy);
      end
   endtask

   task automatic test_reset_mid_run();
      int ndone, lat;
      A = 32'h1111_1111; B = 32'h2222_2222; Cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      checks++;
      if (busy !== 1'b1 || S[15:0] !== 16'h3333) begin
         errors++;
         $display("FAIL partial_slices: got busy=%b S=%h expected 1 xxxx3333", busy, S);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, Cout, V, S} !== 36'h0) begin
         errors++;
         $display("FAIL async_reset: got busy=%b done=%b Cout=%b V=%b S=%h expected all 0",
                  busy, done, Cout, V, S);
      end
      tick();
      rst_n = 1'b1;
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (done || busy) ndone++;
      end
      checks++;
      if (ndone !== 0) begin
         errors++; $display("FAIL no_done_after_abort: got %0d active cycles expected 0", ndone);
      end
      run_add(32'd3, 32'd4, 1'b0, lat);
      check_result("after_reset", lat, 32'h0000_0007, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_back_to_back();
      int lat;
      A = 32'd1; B = 32'd2; Cin = 1'b0; start = 1'b1;
      tick();
      A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      check_result("b2b_first", lat, 32'h0000_0003, 1'b0, 1'b0);
      tick();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
      end
      lat = 0;
      while (!done && lat < 20) begin
         tick();
         lat++;
      end
      // Second done lands 1 + lat edges after the first.
      check_result("b2b_second", lat, 32'hFFFF_FFFE, 1'b1, 1'b0);
      tick();
   endtask

   initial begin
      test_reset();
      test_carry_ripple();
      test_overflow();
      test_carry_in();
      test_start_while_busy();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
